// File: rtl/imem_loader.sv
// Serial instruction-memory loader: takes a length-prefixed byte stream with a
// trailing XOR checksum and turns it into 32-bit word writes.
module imem_loader #(
  parameter int TIMEOUT_CYC = 1000000,
  parameter int MAX_WORDS   = 16384
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        loading,
  output logic        upg_wen_o,
  output logic [13:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        err,
  output logic [14:0] words_written
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [1:0]    bidx_q, bidx_d;
  logic [23:0]   word_q, word_d;
  logic [13:0]   wadr_q, wadr_d;
  logic          wen_q, wen_d;
  logic [13:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [14:0]   ww_q, ww_d;
  logic [7:0]    csum_q, csum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          active;
  logic [15:0]   len_full;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      bidx_q  <= '0;
      word_q  <= '0;
      wadr_q  <= '0;
      wen_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ww_q    <= '0;
      csum_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      bidx_q  <= bidx_d;
      word_q  <= word_d;
      wadr_q  <= wadr_d;
      wen_q   <= wen_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ww_q    <= ww_d;
      csum_q  <= csum_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    bidx_d   = bidx_q;
    word_d   = word_q;
    wadr_d   = wadr_q;
    wen_d    = 1'b0;
    adr_d    = adr_q;
    dat_d    = dat_q;
    done_d   = done_q;
    err_d    = err_q;
    ww_d     = ww_q;
    csum_d   = csum_q;
    tmo_d    = tmo_q;
    len_full = {rx_data, len_q[7:0]};

    active = (state_q == S_LEN0) || (state_q == S_LEN1) ||
             (state_q == S_DATA) || (state_q == S_CSUM);
    if (active) tmo_d = rx_valid ? '0 : tmo_q + 1'b1;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        // A byte arriving together with start is dropped on purpose.
        if (start) begin
          state_d = S_LEN0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          ww_d    = '0;
          csum_d  = '0;
          tmo_d   = '0;
        end
      end
      S_LEN0: if (rx_valid) begin
        len_d[7:0] = rx_data;
        state_d    = S_LEN1;
      end
      S_LEN1: if (rx_valid) begin
        len_d[15:8] = rx_data;
        if (len_full == 16'd0 || int'(len_full) > MAX_WORDS) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          state_d = S_DATA;
          bidx_d  = '0;
          wadr_d  = '0;
        end
      end
      S_DATA: if (rx_valid) begin
        csum_d = csum_q ^ rx_data;
        bidx_d = bidx_q + 1'b1;
        if (bidx_q == 2'd3) begin
          wen_d  = 1'b1;
          adr_d  = wadr_q;
          dat_d  = {rx_data, word_q};
          wadr_d = wadr_q + 1'b1;
          ww_d   = ww_q + 1'b1;
          if (ww_q + 15'd1 == len_q[14:0]) state_d = S_CSUM;
        end else begin
          word_d[bidx_q*8 +: 8] = rx_data;
        end
      end
      S_CSUM: if (rx_valid) begin
        if (rx_data == csum_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // An arriving byte always beats the timeout in the same cycle.
    if (active && !rx_valid && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d = S_ERR;
      err_d   = 1'b1;
    end
  end

  always_comb begin
    loading = (state_q == S_LEN0) || (state_q == S_LEN1) ||
              (state_q == S_DATA) || (state_q == S_CSUM);
  end

  assign upg_wen_o     = wen_q;
  assign upg_adr_o     = adr_q;
  assign upg_dat_o     = dat_q;
  assign upg_done_o    = done_q;
  assign err           = err_q;
  assign words_written = ww_q;

endmodule
